// File: rtl/syncopation_run_ctrl_if.sv
// Bundled accelerator / dynamic-clock / status signals for syncopation_run_ctrl.
// master = the run controller, slave = accelerator, clock generator and host side.
interface syncopation_run_ctrl_if #(
    parameter int DIV_W    = 4,
    parameter int RESULT_W = 32,
    parameter int RUN_W    = 8,
    parameter int CYC_W    = 32
);
    logic                go;
    logic [RUN_W-1:0]    num_runs;
    logic                acc_start;
    logic                acc_finish;
    logic [RESULT_W-1:0] acc_return_val;
    logic [DIV_W-1:0]    acc_div;
    logic                div_valid;
    logic [DIV_W-1:0]    div_in;
    logic [RESULT_W-1:0] result;
    logic [RESULT_W-1:0] result_xor;
    logic [RUN_W-1:0]    runs_done;
    logic [CYC_W-1:0]    cycles;
    logic                busy;
    logic                done;
    logic                timeout;

    modport master (
        input  go, num_runs, acc_finish, acc_return_val, acc_div,
        output acc_start, div_valid, div_in, result, result_xor,
               runs_done, cycles, busy, done, timeout
    );

    modport slave (
        output go, num_runs, acc_finish, acc_return_val, acc_div,
        input  acc_start, div_valid, div_in, result, result_xor,
               runs_done, cycles, busy, done, timeout
    );
endinterface

// File: rtl/syncopation_run_ctrl.sv
// Batch run controller between a LegUp accelerator and the dynamic clock generator.
// Optional per-run watchdog enabled by defining SYNC_WATCHDOG_EN.
//
// state | meaning
// IDLE  | waiting for first go rise after reset
// START | one-cycle acc_start pulse, timers loaded
// WARM  | held at slowest divisor for WARMUP cycles
// EXE   | accelerator divisor forwarded, waiting for acc_finish
// DONE  | batch complete (or timed out), stats held
module syncopation_run_ctrl #(
    parameter int DIV_W    = 4,
    parameter int MIN_DIV  = 2,
    parameter int WARMUP   = 1,
    parameter int RESULT_W = 32,
    parameter int RUN_W    = 8,
    parameter int CYC_W    = 32,
    parameter int TIMEOUT  = 1 << 20
) (
    input logic                  clk,
    input logic                  reset_n,
    syncopation_run_ctrl_if.master bus
);

    localparam logic [DIV_W-1:0] DIV_SLOW = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WARM,
        S_EXE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                go_q;
    logic [RUN_W-1:0]    num_runs_q, num_runs_d;
    logic [7:0]          warm_q, warm_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [RESULT_W-1:0] xor_q, xor_d;
    logic [RUN_W-1:0]    runs_q, runs_d;
    logic [CYC_W-1:0]    cycles_q, cycles_d;
    logic                div_valid_c;
    logic [DIV_W-1:0]    div_in_c;
    logic                go_rise;
    logic [RUN_W-1:0]    runs_inc;

`ifdef SYNC_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    assign go_rise  = bus.go & ~go_q;
    assign runs_inc = runs_q + RUN_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            go_q       <= 1'b0;
            num_runs_q <= '0;
            warm_q     <= '0;
            result_q   <= '0;
            xor_q      <= '0;
            runs_q     <= '0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            go_q       <= bus.go;
            num_runs_q <= num_runs_d;
            warm_q     <= warm_d;
            result_q   <= result_d;
            xor_q      <= xor_d;
            runs_q     <= runs_d;
            cycles_q   <= cycles_d;
        end
    end

`ifdef SYNC_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        num_runs_d  = num_runs_q;
        warm_d      = warm_q;
        result_d    = result_q;
        xor_d       = xor_q;
        runs_d      = runs_q;
        cycles_d    = cycles_q;
        div_valid_c = 1'b0;
        div_in_c    = DIV_SLOW;
`ifdef SYNC_WATCHDOG_EN
        wd_d        = wd_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go_rise) begin
                    num_runs_d = bus.num_runs;
                    result_d   = '0;
                    xor_d      = '0;
                    runs_d     = '0;
                    cycles_d   = '0;
`ifdef SYNC_WATCHDOG_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = (bus.num_runs == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                warm_d  = 8'(WARMUP - 1);
`ifdef SYNC_WATCHDOG_EN
                wd_d    = WD_W'(TIMEOUT - 1);
`endif
                state_d = S_WARM;
            end
            S_WARM, S_EXE: begin
                div_valid_c = 1'b1;
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + CYC_W'(1);
                end
                if (state_q == S_EXE && bus.acc_div >= DIV_W'(MIN_DIV)) begin
                    div_in_c = bus.acc_div;
                end
`ifdef SYNC_WATCHDOG_EN
                wd_d = wd_q - WD_W'(1);
`endif
                // A finish always wins, even on the watchdog's terminal cycle.
                if (bus.acc_finish) begin
                    div_in_c = DIV_SLOW;
                    result_d = bus.acc_return_val;
                    xor_d    = xor_q ^ bus.acc_return_val;
                    runs_d   = runs_inc;
                    state_d  = (runs_inc == num_runs_q) ? S_DONE : S_START;
`ifdef SYNC_WATCHDOG_EN
                end else if (wd_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
`endif
                end else if (state_q == S_WARM) begin
                    if (warm_q == '0) begin
                        state_d = S_EXE;
                    end else begin
                        warm_d = warm_q - 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset forces the clock generator back to its slowest setting without waiting for an edge.
    assign bus.div_valid  = ~reset_n | div_valid_c;
    assign bus.div_in     = reset_n ? div_in_c : DIV_SLOW;
    assign bus.acc_start  = (state_q == S_START);
    assign bus.busy       = (state_q == S_START) || (state_q == S_WARM) || (state_q == S_EXE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.result     = result_q;
    assign bus.result_xor = xor_q;
    assign bus.runs_done  = runs_q;
    assign bus.cycles     = cycles_q;
`ifdef SYNC_WATCHDOG_EN
    assign bus.timeout    = timeout_q;
`else
    assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_syncopation_run_ctrl.sv
// Directed bench for syncopation_run_ctrl; watchdog scenario runs only with SYNC_WATCHDOG_EN.
module tb_syncopation_run_ctrl;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_start  = 0;
    int   s0;
    int   k;

    syncopation_run_ctrl_if #(.DIV_W(4), .RESULT_W(32), .RUN_W(8), .CYC_W(32)) bus ();

    syncopation_run_ctrl #(
        .DIV_W(4), .MIN_DIV(2), .WARMUP(1), .RESULT_W(32),
        .RUN_W(8), .CYC_W(32), .TIMEOUT(16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (bus.acc_start === 1'b1) n_start++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.go = 1'b0;
        bus.num_runs = '0;
        bus.acc_finish = 1'b0;
        bus.acc_return_val = '0;
        bus.acc_div = '0;
        #12;
        check("rst_div_valid", 64'(bus.div_valid), 64'd1);
        check("rst_div_in", 64'(bus.div_in), 64'hF);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_acc_start", 64'(bus.acc_start), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        reset_n = 1'b1;
        step();
        check("idle_div_valid", 64'(bus.div_valid), 64'd0);

        // T1: single run, finish on 10th EXE cycle
        bus.num_runs = 8'd1; bus.acc_div = 4'd5; bus.go = 1'b1;
        step();
        check("t1_start", 64'(bus.acc_start), 64'd1);
        check("t1_start_dv", 64'(bus.div_valid), 64'd0);
        bus.go = 1'b0;
        step();
        check("t1_warm_div", 64'(bus.div_in), 64'hF);
        check("t1_warm_dv", 64'(bus.div_valid), 64'd1);
        check("t1_warm_start", 64'(bus.acc_start), 64'd0);
        step();
        check("t1_exe_div", 64'(bus.div_in), 64'd5);
        repeat (9) step();
        bus.acc_finish = 1'b1; bus.acc_return_val = 32'h1234;
        #1;
        check("t1_cap_div", 64'(bus.div_in), 64'hF);
        check("t1_cap_dv", 64'(bus.div_valid), 64'd1);
        step();
        bus.acc_finish = 1'b0;
        check("t1_result", 64'(bus.result), 64'h1234);
        check("t1_xor", 64'(bus.result_xor), 64'h1234);
        check("t1_runs", 64'(bus.runs_done), 64'd1);
        check("t1_cycles", 64'(bus.cycles), 64'd11);
        check("t1_done", 64'(bus.done), 64'd1);
        check("t1_dv", 64'(bus.div_valid), 64'd0);
        check("t1_timeout", 64'(bus.timeout), 64'd0);

        // T2: MIN_DIV clamp; num_runs change after latch ignored
        bus.num_runs = 8'd1; bus.go = 1'b1;
        step();
        check("t2_start", 64'(bus.acc_start), 64'd1);
        bus.go = 1'b0; bus.num_runs = 8'd5;
        step();
        step();
        bus.acc_div = 4'd1;
        #1;
        check("t2_clamp_div", 64'(bus.div_in), 64'hF);
        check("t2_clamp_dv", 64'(bus.div_valid), 64'd1);
        bus.acc_div = 4'd2;
        #1;
        check("t2_min_div", 64'(bus.div_in), 64'd2);
        bus.acc_finish = 1'b1; bus.acc_return_val = 32'hABCD;
        step();
        bus.acc_finish = 1'b0;
        check("t2_done", 64'(bus.done), 64'd1);
        check("t2_runs", 64'(bus.runs_done), 64'd1);
        check("t2_cycles", 64'(bus.cycles), 64'd2);
        check("t2_xor", 64'(bus.result_xor), 64'hABCD);

        // T3: three runs, second finishes in WARM; go left high throughout
        s0 = n_start;
        bus.num_runs = 8'd3; bus.go = 1'b1;
        step();
        check("t3_start1", 64'(bus.acc_start), 64'd1);
        step();
        step();
        bus.acc_finish = 1'b1; bus.acc_return_val = 32'h1;
        step();
        bus.acc_finish = 1'b0;
        check("t3_start2", 64'(bus.acc_start), 64'd1);
        check("t3_runs1", 64'(bus.runs_done), 64'd1);
        step();
        bus.acc_finish = 1'b1; bus.acc_return_val = 32'h2;
        step();
        bus.acc_finish = 1'b0;
        check("t3_start3", 64'(bus.acc_start), 64'd1);
        check("t3_xor2", 64'(bus.result_xor), 64'h3);
        step();
        step();
        bus.acc_finish = 1'b1; bus.acc_return_val = 32'h4;
        step();
        bus.acc_finish = 1'b0;
        check("t3_result", 64'(bus.result), 64'h4);
        check("t3_xor", 64'(bus.result_xor), 64'h7);
        check("t3_runs", 64'(bus.runs_done), 64'd3);
        check("t3_cycles", 64'(bus.cycles), 64'd5);
        repeat (3) step();
        check("t3_hold_done", 64'(bus.done), 64'd1);
        check("t3_pulses", 64'(n_start - s0), 64'd3);

        // T4: zero-run batch, then stray finish in DONE
        bus.go = 1'b0;
        step();
        s0 = n_start;
        bus.num_runs = 8'd0; bus.go = 1'b1;
        step();
        check("t4_done", 64'(bus.done), 64'd1);
        check("t4_busy", 64'(bus.busy), 64'd0);
        check("t4_runs", 64'(bus.runs_done), 64'd0);
        check("t4_cycles", 64'(bus.cycles), 64'd0);
        check("t4_result", 64'(bus.result), 64'd0);
        bus.acc_finish = 1'b1; bus.acc_return_val = 32'hFF;
        step();
        bus.acc_finish = 1'b0;
        check("t4_ign_result", 64'(bus.result), 64'd0);
        check("t4_ign_runs", 64'(bus.runs_done), 64'd0);
        check("t4_no_start", 64'(n_start - s0), 64'd0);

        // T5: async reset mid-EXE
        bus.go = 1'b0;
        step();
        bus.num_runs = 8'd1; bus.acc_div = 4'd7; bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        step();
        step();
        check("t5_exe_div", 64'(bus.div_in), 64'd7);
        check("t5_exe_cycles", 64'(bus.cycles), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_dv", 64'(bus.div_valid), 64'd1);
        check("t5_rst_div", 64'(bus.div_in), 64'hF);
        check("t5_rst_busy", 64'(bus.busy), 64'd0);
        check("t5_rst_cycles", 64'(bus.cycles), 64'd0);
        #1 reset_n = 1'b1;
        step();
        check("t5_idle_dv", 64'(bus.div_valid), 64'd0);
        check("t5_idle_busy", 64'(bus.busy), 64'd0);
        check("t5_idle_done", 64'(bus.done), 64'd0);

`ifdef SYNC_WATCHDOG_EN
        // T6: no finish, watchdog expires after 16 WARM/EXE cycles
        s0 = n_start;
        bus.num_runs = 8'd2; bus.go = 1'b1;
        step();
        k = 0;
        while (bus.done !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check("t6_wd_steps", 64'(k), 64'd17);
        check("t6_timeout", 64'(bus.timeout), 64'd1);
        check("t6_runs", 64'(bus.runs_done), 64'd0);
        check("t6_cycles", 64'(bus.cycles), 64'd16);
        repeat (2) step();
        check("t6_hold_done", 64'(bus.done), 64'd1);
        check("t6_pulses", 64'(n_start - s0), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
